cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common Data Bus arbiter for the Tomasulo core. Sits between the execution units (integer, multiplier, divider, load/store) and the CDB consumed by the issue queues, ROB and register status table. Each cycle it selects at most one completing unit using two-level round-robin priority (urgent, then normal), and drives a registered CDB broadcast (`cdb_tag`, `cdb_data`, `cdb_data_valid`) for exactly one cycle per winner.

## Interface
Parameters:
- `N_REQ`, 4, number of requesting execution units (index 0 = INT, 1 = MUL, 2 = DIV, 3 = MEM); legal range 2..8.
- `TAG_W`, 6, ROB/physical tag width; matches the issue-queue tag width.
- `DATA_W`, 32, result width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid[N_REQ]`  in  1  unit i has a result to publish.
- `req_urgent[N_REQ]`  in  1  unit i requests the high-priority class (e.g. MEM replay); ignored unless `req_valid[i]`.
- `req_tag[N_REQ]`  in  TAG_W  destination tag of unit i's result.
- `req_data[N_REQ]`  in  DATA_W  result value of unit i.
- `req_grant[N_REQ]`  out  1  one-hot or zero; unit i's result is accepted this cycle.
- `flush`  in  1  pipeline flush (mispredict/exception); suppresses grants and broadcast.
- `cdb_data_valid`  out  1  CDB broadcast valid.
- `cdb_tag`  out  TAG_W  broadcast tag.
- `cdb_data`  out  DATA_W  broadcast data.
- `cdb_src`  out  clog2(N_REQ)  index of the unit that produced the current broadcast.

## Operation
- Transfer occurs on a rising edge where `req_valid[i] && req_grant[i]`. A requester holds `req_valid`, `req_urgent`, `req_tag` and `req_data` stable until granted. The arbiter does not buffer ungranted requests.
- Class selection: if any `req_valid[i] && req_urgent[i]`, only urgent requesters compete. Otherwise all valid requesters compete.
- Within the competing set, pick round-robin starting at pointer `rr_ptr`. Scan i = `rr_ptr`, `rr_ptr+1`, … modulo N_REQ, wrapping from N_REQ-1 to 0. The first competitor found wins.
- Urgent and normal classes share a single `rr_ptr`.
- On a transfer by unit k, `rr_ptr` ← (k+1) mod N_REQ. With no transfer, `rr_ptr` holds.
- `req_grant` is combinational from `req_valid`, `req_urgent`, `rr_ptr`, `flush` and `rst`. It is never asserted for a non-valid requester.
- Broadcast register:
  - On a transfer by k: `cdb_data_valid` ← 1, `cdb_tag` ← `req_tag[k]`, `cdb_data` ← `req_data[k]`, `cdb_src` ← k.
  - With no transfer: `cdb_data_valid` ← 0, and `cdb_tag`, `cdb_data`, `cdb_src` hold their last values.
- Flush:
  - While `flush` = 1, all `req_grant` = 0 and `rr_ptr` holds.
  - On the edge where `flush` is sampled 1, `cdb_data_valid` ← 0. This also kills a broadcast launched in the previous cycle, so it is not visible in the cycle after flush.
- Fairness: a unit holding `req_valid` with no urgent traffic from other units is granted within N_REQ cycles.
- Starvation by continuous urgent traffic is permitted. Urgent use is bounded by the MEM unit.

## Timing
- Reset values (after any edge with `rst` = 1):
  - `cdb_data_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0, `cdb_src` = 0, `rr_ptr` = 0.
  - `req_grant` = all 0 while `rst` is high.
- `rst` dominates `flush` and requests. A reset mid-stream discards any in-flight broadcast. Requesters re-present after reset.
- Latency: grant in cycle T; broadcast visible (`cdb_data_valid` = 1) in cycle T+1 for exactly one cycle.
- Throughput: one broadcast per cycle; back-to-back grants to different or the same unit are allowed.
- A unit that is granted and raises a new request the next cycle competes normally. Its priority is lowest because `rr_ptr` has moved past it.
- `req_grant` may change within a cycle only in response to input changes. There are no combinational paths from `cdb_*` back to `req_grant`.

## Test plan
- Reset: hold `rst` 2 cycles with all `req_valid` = 1 -> `req_grant` = 0000, `cdb_data_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0, `cdb_src` = 0. First post-reset grant goes to unit 0.
- Round-robin rotation: all four valid continuously with tags 0x01..0x04 and data 0xA0..0xA3 -> grants 0,1,2,3,0 on consecutive cycles. Broadcast tags 0x01,0x02,0x03,0x04,0x01 appear one cycle later, each with `cdb_data_valid` = 1 and matching `cdb_src`.
- Urgent override: `rr_ptr` = 0, units 0 and 2 valid, unit 3 valid+urgent -> grant 3. The next cycle (unit 3 dropped) grants 0, because `rr_ptr` = 0 after the wrap.
- Single sparse requester: only unit 2 valid for one cycle, tag 0x15, data 0xDEADBEEF -> `req_grant` = 0100 that cycle. The next cycle shows `cdb_data_valid` = 1, tag 0x15, data 0xDEADBEEF, `cdb_src` = 2. The following cycle shows `cdb_data_valid` = 0 with tag and data held.
- Flush: grant unit 1 at T, assert `flush` at T+1 with units 1 and 3 valid -> no grant at T+1. `cdb_data_valid` = 0 at T+2. Grant resumes at T+2 with unit 3 first (`rr_ptr` = 2).
- Reset mid-stream: `rst` asserted the cycle after a grant -> `cdb_data_valid` = 0 next cycle (broadcast dropped) and `rr_ptr` returns to 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: two-level (urgent, normal) round-robin selection among
// execution units with a registered one-cycle CDB broadcast per winner.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_urgent,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_grant,
  input  logic                    flush,
  output logic                    cdb_data_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [SRC_W-1:0]        cdb_src
);

  localparam logic [SRC_W:0]   NREQ_EXT = (SRC_W + 1)'(N_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_REQ - 1);

  logic [SRC_W-1:0] rr_ptr;
  logic [N_REQ-1:0] urgent_set;
  logic [N_REQ-1:0] compete;
  logic [SRC_W-1:0] win;
  logic             found;
  logic [SRC_W:0]   sum;
  logic [SRC_W-1:0] idx;
  logic             xfer;

  assign urgent_set = req_valid & req_urgent;
  assign compete    = (|urgent_set) ? urgent_set : req_valid;

  // Scan from rr_ptr upward with explicit wrap so non-power-of-two N_REQ works.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
      if (sum >= NREQ_EXT) begin
        sum = sum - NREQ_EXT;
      end
      idx = sum[SRC_W-1:0];
      if (!found && compete[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    req_grant = '0;
    if (found && !flush && !rst) begin
      req_grant[win] = 1'b1;
    end
  end

  assign xfer = |req_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      cdb_data_valid <= 1'b0;
      cdb_tag        <= '0;
      cdb_data       <= '0;
      cdb_src        <= '0;
    end else if (xfer) begin
      rr_ptr         <= (win == LAST_IDX) ? '0 : win + 1'b1;
      cdb_data_valid <= 1'b1;
      cdb_tag        <= req_tag[win*TAG_W +: TAG_W];
      cdb_data       <= req_data[win*DATA_W +: DATA_W];
      cdb_src        <= win;
    end else begin
      cdb_data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with N_REQ=4 (INT, MUL, DIV, MEM).
module tb_cdb_arbiter;

  localparam int N_REQ  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_urgent;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_grant;
  logic                    flush;
  logic                    cdb_data_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [1:0]              cdb_src;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_urgent     (req_urgent),
    .req_tag        (req_tag),
    .req_data       (req_data),
    .req_grant      (req_grant),
    .flush          (flush),
    .cdb_data_valid (cdb_data_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .cdb_src        (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Grant is combinational: sample it mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic [3:0] exp_grant);
    @(negedge clk);
    check(tag, 64'(req_grant), 64'(exp_grant));
    @(posedge clk);
    #1;
  endtask

  task automatic check_cdb(input string tag, input logic v, input logic [5:0] t,
                           input logic [31:0] d, input logic [1:0] s);
    check({tag, "_v"}, 64'(cdb_data_valid), 64'(v));
    check({tag, "_tag"}, 64'(cdb_tag), 64'(t));
    check({tag, "_data"}, 64'(cdb_data), 64'(d));
    check({tag, "_src"}, 64'(cdb_src), 64'(s));
  endtask

  task automatic default_payload();
    req_tag  = {6'h04, 6'h03, 6'h02, 6'h01};
    req_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 4'b1111;
    req_urgent = 4'b0000;
    default_payload();

    // Reset held two cycles with everyone requesting.
    cyc("rst_grant0", 4'b0000);
    cyc("rst_grant1", 4'b0000);
    check_cdb("rst", 1'b0, 6'h00, 32'h0, 2'd0);

    // Rotation 0,1,2,3,0 with broadcast one cycle after each grant.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("rot_grant%0d", i), 4'(1 << (i % 4)));
      check_cdb($sformatf("rot%0d", i), 1'b1, 6'(i % 4 + 1), 32'hA0 + 32'(i % 4), 2'(i % 4));
    end

    // Move rr_ptr to 0 by granting unit 3 alone.
    req_valid = 4'b1000;
    cyc("pre_urg_grant", 4'b1000);
    check_cdb("pre_urg", 1'b1, 6'h04, 32'hA3, 2'd3);

    // Urgent override: unit 3 urgent beats 0 and 2 although rr_ptr = 0.
    req_valid  = 4'b1101;
    req_urgent = 4'b1000;
    cyc("urg_grant", 4'b1000);
    check_cdb("urg", 1'b1, 6'h04, 32'hA3, 2'd3);
    req_valid  = 4'b0101;
    req_urgent = 4'b0000;
    cyc("post_urg_grant", 4'b0001);
    check_cdb("post_urg", 1'b1, 6'h01, 32'hA0, 2'd0);

    // Urgent flag on a non-valid unit is ignored.
    req_valid  = 4'b0100;
    req_urgent = 4'b0010;
    req_tag[2*TAG_W +: TAG_W]    = 6'h15;
    req_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    cyc("sparse_grant", 4'b0100);
    check_cdb("sparse", 1'b1, 6'h15, 32'hDEADBEEF, 2'd2);
    req_valid  = 4'b0000;
    req_urgent = 4'b0000;
    default_payload();
    cyc("idle_grant", 4'b0000);
    check_cdb("idle_hold", 1'b0, 6'h15, 32'hDEADBEEF, 2'd2);

    // Flush: rr_ptr = 3 now; grant 1 alone to set rr_ptr = 2.
    req_valid = 4'b0010;
    cyc("fl_pre_grant", 4'b0010);
    check_cdb("fl_pre", 1'b1, 6'h02, 32'hA1, 2'd1);
    flush     = 1'b1;
    req_valid = 4'b1010;
    cyc("fl_grant", 4'b0000);
    check_cdb("fl", 1'b0, 6'h02, 32'hA1, 2'd1);
    flush = 1'b0;
    cyc("fl_resume_grant", 4'b1000);
    check_cdb("fl_resume", 1'b1, 6'h04, 32'hA3, 2'd3);

    // Reset the cycle after a grant: broadcast dropped, rr_ptr back to 0.
    req_valid = 4'b0010;
    cyc("mrst_pre_grant", 4'b0010);
    rst       = 1'b1;
    req_valid = 4'b1111;
    cyc("mrst_grant", 4'b0000);
    check_cdb("mrst", 1'b0, 6'h00, 32'h0, 2'd0);
    rst = 1'b0;
    req_valid = 4'b1110;
    cyc("mrst_after_grant", 4'b0010);
    req_valid = 4'b1111;
    cyc("mrst_after2_grant", 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
